// File: rtl/rs_parity_encoder.sv
// rs_parity_encoder: serial systematic RS(12,8) parity encoder over GF(16).
// Field polynomial x^4 + x + 1. Data symbols stream in one per handshake and
// parity accumulates as pp[j] ^= G[i][j] * vp[i].
// Optional build macro RS_ENC_ERRINJ_EN adds inj_en/inj_pos/inj_sym, which
// corrupt one symbol of the codeword as it is captured.

module rs_parity_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_sym,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_vp,
    output logic [15:0] out_pp
`ifdef RS_ENC_ERRINJ_EN
    ,
    input  logic        inj_en,
    input  logic [3:0]  inj_pos,
    input  logic [3:0]  inj_sym
`endif
);

    localparam int unsigned SYM_W  = 4;
    localparam int unsigned N_DATA = 8;
    localparam int unsigned N_PAR  = 4;
    localparam int unsigned CNT_W  = 3;

    // Generator coefficients G = Hp^-1 * Hv, row = data index, column = parity index.
    localparam logic [SYM_W-1:0] G_TAB [N_DATA][N_PAR] = '{
        '{4'd12, 4'd13, 4'd8,  4'd6 },
        '{4'd7,  4'd9,  4'd15, 4'd5 },
        '{4'd13, 4'd9,  4'd10, 4'd13},
        '{4'd8,  4'd15, 4'd3,  4'd6 },
        '{4'd7,  4'd13, 4'd13, 4'd14},
        '{4'd2,  4'd14, 4'd6,  4'd14},
        '{4'd2,  4'd11, 4'd5,  4'd5 },
        '{4'd13, 4'd12, 4'd8,  4'd7 }
    };

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // Multiply by alpha, reducing x^4 to x + 1.
    function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] a);
        return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
    endfunction

    // GF(16) multiplier cell: shift-and-add over the four bits of b.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                 input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] a1, a2, a3;
        a1 = gf_xtime(a);
        a2 = gf_xtime(a1);
        a3 = gf_xtime(a2);
        return ({SYM_W{b[0]}} & a)  ^ ({SYM_W{b[1]}} & a1) ^
               ({SYM_W{b[2]}} & a2) ^ ({SYM_W{b[3]}} & a3);
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SYM_W-1:0]   acc_q    [N_PAR];
    logic [SYM_W-1:0]   acc_d    [N_PAR];
    logic [SYM_W-1:0]   data_q   [N_DATA];
    logic [SYM_W-1:0]   data_d   [N_DATA];
    logic [SYM_W-1:0]   out_vp_q [N_DATA];
    logic [SYM_W-1:0]   out_vp_d [N_DATA];
    logic [SYM_W-1:0]   out_pp_q [N_PAR];
    logic [SYM_W-1:0]   out_pp_d [N_PAR];
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic [SYM_W-1:0]   acc_upd  [N_PAR];
    logic [SYM_W-1:0]   vp_fin   [N_DATA];
    logic [SYM_W-1:0]   pp_fin   [N_PAR];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            acc_q       <= '{default: '0};
            data_q      <= '{default: '0};
            out_vp_q    <= '{default: '0};
            out_pp_q    <= '{default: '0};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            out_vp_q    <= out_vp_d;
            out_pp_q    <= out_pp_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state, accumulation and codeword capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        data_d      = data_q;
        out_vp_d    = out_vp_q;
        out_pp_d    = out_pp_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        for (int unsigned j = 0; j < N_PAR; j++) begin
            acc_upd[j] = acc_q[j] ^ gf_mul(G_TAB[cnt_q][2'(j)], in_sym);
        end

        // Final codeword as seen on the edge that takes the eighth symbol.
        vp_fin    = data_q;
        vp_fin[7] = in_sym;
        pp_fin    = acc_upd;
`ifdef RS_ENC_ERRINJ_EN
        if (inj_en && (inj_pos < 4'd12)) begin
            if (!inj_pos[3]) begin
                vp_fin[inj_pos[2:0]] = vp_fin[inj_pos[2:0]] ^ inj_sym;
            end else begin
                pp_fin[inj_pos[1:0]] = pp_fin[inj_pos[1:0]] ^ inj_sym;
            end
        end
`endif

        case (state_q)
            COLLECT: begin
                if (in_valid && in_ready_q) begin
                    acc_d         = acc_upd;
                    data_d[cnt_q] = in_sym;
                    cnt_d         = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d     = HOLD;
                        out_vp_d    = vp_fin;
                        out_pp_d    = pp_fin;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d     = COLLECT;
                    cnt_d       = '0;
                    acc_d       = '{default: '0};
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_vp    = {out_vp_q[7], out_vp_q[6], out_vp_q[5], out_vp_q[4],
                        out_vp_q[3], out_vp_q[2], out_vp_q[1], out_vp_q[0]};
    assign out_pp    = {out_pp_q[3], out_pp_q[2], out_pp_q[1], out_pp_q[0]};

endmodule

// File: doc/rs_parity_encoder.md
RS_PARITY_ENCODER -- requirements
Module: rs_parity_encoder

Interface
REQ-001 SHALL have no parameters; code fixed at 8 data + 4 parity symbols over GF(16).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_sym carries one data symbol.
REQ-005 in_ready  output  1  block accepts a data symbol this cycle.
REQ-006 in_sym  input  4  data symbol, GF(16) element.
REQ-007 out_valid  output  1  codeword on out_vp/out_pp valid.
REQ-008 out_ready  input  1  consumer accepts codeword.
REQ-009 out_vp  output  32  data symbols, symbol i at bits [4i+3:4i].
REQ-010 out_pp  output  16  parity symbols, symbol j at bits [4j+3:4j].

Function
REQ-011 SHALL accept data symbols in order vp[0]..vp[7], one per handshake (in_valid & in_ready).
REQ-012 SHALL choose pp so that every row of H gives a zero syndrome over (vp[0..7], pp[0..3]), using the team GF(16) multiplier cell. H rows, coefficients listed for vp0..vp7 | pp0..pp3:
  S0: 9,13,15,14,7,10,5,11 | 12,6,3,8
  S1: 13,14,10,11,6,8,2,9 | 15,7,5,12
  S2: 15,10,12,8,1,15,10,12 | 8,1,15,10
  S3: 14,11,8,9,7,12,4,13 | 10,6,2,15
REQ-013 SHALL realise parity as pp[j] = XOR over i of G[i][j]*vp[i], G = Hp^-1 * Hv computed offline and held as 32 constants.
REQ-014 SHALL accumulate serially: on each input handshake, acc[j] <= acc[j] ^ G[cnt][j]*in_sym for all j, and store in_sym into data register slot cnt.
REQ-015 SHALL use a 3-bit symbol counter cnt, incremented per input handshake, wrapping 7->0.
REQ-016 FSM states: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 COLLECT->HOLD on input handshake with cnt==7; out_vp/out_pp load final values on that edge; out_valid asserts the next cycle (latency 1 cycle after 8th symbol).
REQ-018 HOLD->COLLECT on out_valid & out_ready; accumulators and cnt clear on the same edge.
REQ-019 out_vp/out_pp SHALL stay stable throughout HOLD.
REQ-020 in_valid while in HOLD SHALL be ignored; no symbol consumed.
REQ-021 in_valid gaps in COLLECT SHALL not disturb cnt or accumulators.
REQ-022 Throughput: one codeword per 9 cycles at best (8 collect + 1 hold).

Reset
REQ-023 rst_n low SHALL asynchronously force state COLLECT, cnt=0, acc=0, out_vp=0, out_pp=0, out_valid=0, in_ready=1 once released.
REQ-024 Reset mid-collection or mid-hold SHALL discard the partial or held codeword; no output follows.

Configuration
REQ-025 Macro RS_ENC_ERRINJ_EN: when defined, adds inputs inj_en (1), inj_pos (4), inj_sym (4); on the COLLECT->HOLD edge, if inj_en=1 and inj_pos<12, the symbol at index inj_pos (0-7 = vp, 8-11 = pp[inj_pos-8]) SHALL be XORed with inj_sym; inj_pos>=12 SHALL have no effect.
REQ-026 Without RS_ENC_ERRINJ_EN, these ports SHALL be absent and the codeword is always clean.

Verification
REQ-027 Eight 4'h0 symbols -> out_vp=32'h0, out_pp=16'h0, out_valid one cycle after 8th handshake.
REQ-028 4'h1 then seven 4'h0 -> out_vp=32'h00000001; all four H syndromes of the output equal 0.
REQ-029 1000 random 8-symbol words with random in_valid gaps -> every codeword has zero syndromes; out_vp matches input order.
REQ-030 out_ready held low 5 cycles in HOLD -> out_valid=1, outputs stable, in_ready=0, extra in_valid ignored; first symbol after release lands in slot 0.
REQ-031 rst_n pulsed low after 3 symbols -> out_valid=0; next 8 symbols give a correct codeword.
REQ-032 With RS_ENC_ERRINJ_EN: inj_en=1, inj_pos=9, inj_sym=4'h5 -> out_pp[1] equals clean value ^ 4'h5; inj_pos=12 -> clean codeword.
